// File: rtl/wb_bus_pkg.sv
// Shared types and helpers for the Wishbone shared-bus interconnect.
package wb_bus_pkg;

  localparam int unsigned MAX_AW       = 64;
  localparam int unsigned MAX_SEL_BITS = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  typedef struct packed {
    logic                    mapped;
    logic [MAX_SEL_BITS-1:0] idx;
  } dec_t;

  // Timeout counter must hold values 0..timeout_cyc.
  function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
    int unsigned w;
    w = $clog2(timeout_cyc + 1);
    return (w == 0) ? 1 : w;
  endfunction

  // Slave index is the top sel_bits of the address; mapped when below num_slaves.
  function automatic dec_t slave_decode(input logic [MAX_AW-1:0] adr,
                                        input int unsigned      aw,
                                        input int unsigned      sel_bits,
                                        input int unsigned      num_slaves);
    logic [MAX_AW-1:0] field;
    dec_t              d;
    field    = (adr >> (aw - sel_bits)) & ((MAX_AW'(1) << sel_bits) - MAX_AW'(1));
    d.idx    = MAX_SEL_BITS'(field);
    d.mapped = (field < MAX_AW'(num_slaves));
    return d;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational N-way round-robin arbiter; search starts just after ptr.
module wb_rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_shared_bus.sv
// Wishbone shared-bus interconnect: round-robin ownership, upper-bit address
// decode, error on unmapped addresses and a per-transfer timeout watchdog.
module wb_shared_bus
  import wb_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned SEL_BITS    = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS*AW-1:0]       m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]       m_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  output logic [DW-1:0]                   m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_MASTERS-1:0]          m_rty_o,
  output logic [AW-1:0]                   s_adr_o,
  output logic [DW-1:0]                   s_dat_o,
  output logic [(DW/8)-1:0]               s_sel_o,
  output logic                            s_we_o,
  output logic [NUM_SLAVES-1:0]           s_cyc_o,
  output logic [NUM_SLAVES-1:0]           s_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]        s_dat_i,
  input  logic [NUM_SLAVES-1:0]           s_ack_i,
  input  logic [NUM_SLAVES-1:0]           s_err_i,
  input  logic [NUM_SLAVES-1:0]           s_rty_i,
  output logic [NUM_MASTERS-1:0]          grant_o,
  output logic                            busy_o
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned MPW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CW  = cnt_width(TIMEOUT_CYC);

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, arb_grant;
  logic [MPW-1:0]         rr_ptr_q, rr_ptr_d, gidx;
  logic                   err_q, err_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic                   owned, g_cyc, g_stb, g_we, mapped;
  logic [AW-1:0]          g_adr;
  logic [DW-1:0]          g_dat;
  logic [SW-1:0]          g_sel;
  logic [SIW-1:0]         sidx;
  logic                   sl_ack, sl_err, sl_rty, stb_act, resp;
  dec_t                   dec;

  wb_rr_arbiter #(
    .N  (NUM_MASTERS),
    .PW (MPW)
  ) u_arb (
    .req   (m_cyc_i),
    .ptr   (rr_ptr_q),
    .grant (arb_grant)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= MPW'(NUM_MASTERS - 1);
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Owner index and its request signals
  always_comb begin
    gidx = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) gidx = MPW'(k);
    end
  end

  assign owned  = (state_q == OWNED);
  assign g_cyc  = owned & m_cyc_i[gidx];
  assign g_stb  = owned & m_stb_i[gidx];
  assign g_we   = owned & m_we_i[gidx];
  assign g_adr  = owned ? m_adr_i[gidx*AW +: AW] : '0;
  assign g_dat  = owned ? m_dat_i[gidx*DW +: DW] : '0;
  assign g_sel  = owned ? m_sel_i[gidx*SW +: SW] : '0;
  assign dec    = slave_decode(MAX_AW'(g_adr), AW, SEL_BITS, NUM_SLAVES);
  assign mapped = owned & dec.mapped;
  assign sidx   = SIW'(dec.idx);

  // Next-state: grab on any request, release when the owner drops cyc
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = OWNED;
          grant_d = arb_grant;
        end
      end
      OWNED: begin
        if (!g_cyc) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = gidx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output muxing and response routing
  always_comb begin
    s_adr_o = g_adr;
    s_dat_o = g_dat;
    s_sel_o = g_sel;
    s_we_o  = g_we;
    s_cyc_o = '0;
    s_stb_o = '0;
    sl_ack  = 1'b0;
    sl_err  = 1'b0;
    sl_rty  = 1'b0;
    m_dat_o = '0;
    if (mapped) begin
      s_cyc_o[sidx] = g_cyc;
      s_stb_o[sidx] = g_cyc & g_stb & ~err_q;
      sl_ack        = g_cyc & s_ack_i[sidx];
      sl_err        = g_cyc & s_err_i[sidx];
      sl_rty        = g_cyc & s_rty_i[sidx];
      m_dat_o       = s_dat_i[sidx*DW +: DW];
    end
    m_ack_o = grant_q & {NUM_MASTERS{sl_ack}};
    m_err_o = grant_q & {NUM_MASTERS{sl_err | err_q}};
    m_rty_o = grant_q & {NUM_MASTERS{sl_rty}};
  end

  assign stb_act = g_cyc & g_stb;
  assign resp    = sl_ack | sl_err | sl_rty;

  // Error pulse generation: unmapped strobe or watchdog expiry
  always_comb begin
    err_d = 1'b0;
    cnt_d = '0;
    if (stb_act && !err_q) begin
      if (!mapped) begin
        err_d = 1'b1;
      end else if (!resp) begin
        if (cnt_q == CW'(TIMEOUT_CYC)) err_d = 1'b1;
        else                           cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = owned;

endmodule
